// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit, stock-checked selection, req/ack dispense, unit-by-unit change.
// Optional SALES_AUDIT_EN adds saturating sales_count / refund_count outputs.
module vend_controller #(
    parameter int NUM_SLOTS  = 4,
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 7,
    parameter int STOCK_INIT = 5,
    parameter int CW         = 3,
    localparam int IW        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           coin,
    input  logic                 sel_valid,
    input  logic [IW-1:0]        sel_id,
    input  logic                 cancel,
    input  logic                 vend_ack,
    output logic                 vend_req,
    output logic [IW-1:0]        vend_id,
    output logic                 change_pulse,
    output logic [CW-1:0]        credit,
    output logic                 busy,
    output logic [NUM_SLOTS-1:0] sold_out,
    output logic                 coin_reject,
`ifdef SALES_AUDIT_EN
    output logic [15:0]          sales_count,
    output logic [15:0]          refund_count,
`endif
    output logic                 sel_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] VEND    = 2'd2;
    localparam logic [1:0] CHANGE  = 2'd3;

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
    localparam logic [CW:0]   MAX_C   = (CW+1)'(MAX_CREDIT);
    localparam logic [3:0]    STOCK_C = 4'(STOCK_INIT);

    logic [1:0]    state;
    logic [3:0]    stock [NUM_SLOTS];
    logic [CW:0]   coin_sum;
    logic          coin_ok;
    logic          sel_ok;

    // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
    always_comb begin
        coin_sum = {1'b0, credit} + (CW+1)'(coin);
        coin_ok  = ((coin == 2'd1) || (coin == 2'd2)) && (coin_sum <= MAX_C);
        sel_ok   = (int'(sel_id) < NUM_SLOTS) && (stock[sel_id] != 4'd0) && (credit >= PRICE_C);
    end

    // NOTE: sequential state uses non-blocking assignments so every decision sees start-of-cycle values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            credit       <= '0;
            vend_req     <= 1'b0;
            vend_id      <= '0;
            change_pulse <= 1'b0;
            busy         <= 1'b0;
            coin_reject  <= 1'b0;
            sel_err      <= 1'b0;
            sold_out     <= {NUM_SLOTS{STOCK_INIT == 0}};
            // NOTE: the stock array is a handful of flops, not a RAM, so resetting every entry is intended.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                stock[i] <= STOCK_C;
            end
`ifdef SALES_AUDIT_EN
            sales_count  <= '0;
            refund_count <= '0;
`endif
        end else begin
            coin_reject  <= 1'b0;
            sel_err      <= 1'b0;
            change_pulse <= 1'b0;

            case (state)
                IDLE, COLLECT: begin
                    if (cancel && (state == COLLECT)) begin
                        state       <= CHANGE;
                        busy        <= 1'b1;
                        coin_reject <= (coin != 2'd0);
`ifdef SALES_AUDIT_EN
                        if (refund_count != 16'hFFFF) refund_count <= refund_count + 16'd1;
`endif
                    end else if (sel_valid && sel_ok) begin
                        state       <= VEND;
                        busy        <= 1'b1;
                        vend_req    <= 1'b1;
                        vend_id     <= sel_id;
                        coin_reject <= (coin != 2'd0);
                    end else begin
                        // A refused selection does not consume the coin offered in the same cycle.
                        if (sel_valid) sel_err <= 1'b1;
                        if (coin_ok) begin
                            credit <= coin_sum[CW-1:0];
                            state  <= COLLECT;
                        end else if (coin != 2'd0) begin
                            coin_reject <= 1'b1;
                        end
                    end
                end

                VEND: begin
                    coin_reject <= (coin != 2'd0);
                    if (vend_ack) begin
                        vend_req <= 1'b0;
                        credit   <= credit - PRICE_C;
                        if (stock[vend_id] != 4'd0) stock[vend_id] <= stock[vend_id] - 4'd1;
                        if (stock[vend_id] <= 4'd1) sold_out[vend_id] <= 1'b1;
`ifdef SALES_AUDIT_EN
                        if (sales_count != 16'hFFFF) sales_count <= sales_count + 16'd1;
`endif
                        if (credit != PRICE_C) begin
                            state <= CHANGE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                CHANGE: begin
                    coin_reject <= (coin != 2'd0);
                    if (credit != '0) begin
                        change_pulse <= 1'b1;
                        credit       <= credit - CW'(1);
                    end
                    // Leave on the pulse that empties the credit so pulses run back to back.
                    if (credit <= CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed, table-driven bench for vend_controller (default parameters).
// Each record gives one cycle of inputs and the registered outputs expected after that clock edge.
module tb_vend_controller;

    localparam int NUM_SLOTS = 4;
    localparam int CW        = 3;
    localparam int IW        = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           coin = '0;
    logic                 sel_valid = 1'b0;
    logic [IW-1:0]        sel_id = '0;
    logic                 cancel = 1'b0;
    logic                 vend_ack = 1'b0;
    logic                 vend_req;
    logic [IW-1:0]        vend_id;
    logic                 change_pulse;
    logic [CW-1:0]        credit;
    logic                 busy;
    logic [NUM_SLOTS-1:0] sold_out;
    logic                 coin_reject;
    logic                 sel_err;
`ifdef SALES_AUDIT_EN
    logic [15:0]          sales_count;
    logic [15:0]          refund_count;
`endif

    always #5 clk = ~clk;

    vend_controller dut (
        .clk          (clk),
        .rst          (rst),
        .coin         (coin),
        .sel_valid    (sel_valid),
        .sel_id       (sel_id),
        .cancel       (cancel),
        .vend_ack     (vend_ack),
        .vend_req     (vend_req),
        .vend_id      (vend_id),
        .change_pulse (change_pulse),
        .credit       (credit),
        .busy         (busy),
        .sold_out     (sold_out),
        .coin_reject  (coin_reject),
`ifdef SALES_AUDIT_EN
        .sales_count  (sales_count),
        .refund_count (refund_count),
`endif
        .sel_err      (sel_err)
    );

    typedef struct {
        logic                 rst;
        logic [1:0]           coin;
        logic                 sel;
        logic [IW-1:0]        id;
        logic                 cancel;
        logic                 ack;
        logic [CW-1:0]        e_credit;
        logic                 e_req;
        logic [IW-1:0]        e_id;
        logic                 e_pulse;
        logic                 e_busy;
        logic                 e_rej;
        logic                 e_err;
        logic [NUM_SLOTS-1:0] e_sold;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [1:0] c, input logic s, input logic [IW-1:0] id,
                                input logic cn, input logic a, input logic [CW-1:0] ec, input logic er,
                                input logic [IW-1:0] eid, input logic ep, input logic eb, input logic ej,
                                input logic ee, input logic [NUM_SLOTS-1:0] es);
        vec_t v;
        v.rst = r; v.coin = c; v.sel = s; v.id = id; v.cancel = cn; v.ack = a;
        v.e_credit = ec; v.e_req = er; v.e_id = eid; v.e_pulse = ep; v.e_busy = eb;
        v.e_rej = ej; v.e_err = ee; v.e_sold = es;
        return v;
    endfunction

    // Drive one cycle of inputs, clock once, then compare outputs 1 ns after the edge.
    task automatic run_vec(input vec_t v, input string tag);
        rst = v.rst; coin = v.coin; sel_valid = v.sel; sel_id = v.id;
        cancel = v.cancel; vend_ack = v.ack;
        @(posedge clk);
        #1;
        check({tag, " credit"},       32'(credit),       32'(v.e_credit));
        check({tag, " vend_req"},     32'(vend_req),     32'(v.e_req));
        check({tag, " change_pulse"}, 32'(change_pulse), 32'(v.e_pulse));
        check({tag, " busy"},         32'(busy),         32'(v.e_busy));
        check({tag, " coin_reject"},  32'(coin_reject),  32'(v.e_rej));
        check({tag, " sel_err"},      32'(sel_err),      32'(v.e_err));
        check({tag, " sold_out"},     32'(sold_out),     32'(v.e_sold));
        if (v.e_req) check({tag, " vend_id"}, 32'(vend_id), 32'(v.e_id));
    endtask

    vec_t tbl [30];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        //              rst coin sel id can ack | cred req id pls bsy rej err sold
        tbl[0]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        // coins 2 then 1, select slot 1, ack on the third vend cycle
        tbl[1]  = mk(0, 2, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 1, 0, 0,   3, 1, 1, 0, 1, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 1, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 1, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        // build credit 6, overflow coin rejected
        tbl[8]  = mk(0, 2, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 2, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 2, 0, 0, 0, 0,   6, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 2, 0, 0, 0, 0,   6, 0, 0, 0, 0, 1, 0, 0);
        // vend slot 0 from credit 6: three change pulses
        tbl[12] = mk(0, 0, 1, 0, 0, 0,   6, 1, 0, 0, 1, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 1,   3, 0, 0, 0, 1, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0,   2, 0, 0, 1, 1, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        // invalid coin in IDLE, then refused selection with credit 2
        tbl[18] = mk(0, 3, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0);
        tbl[19] = mk(0, 2, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0);
        tbl[20] = mk(0, 0, 1, 1, 0, 0,   2, 0, 0, 0, 0, 0, 1, 0);
        // credit 5, cancel with a coin in the same cycle, five refund pulses
        tbl[21] = mk(0, 2, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 0, 0);
        tbl[22] = mk(0, 1, 0, 0, 0, 0,   5, 0, 0, 0, 0, 0, 0, 0);
        tbl[23] = mk(0, 1, 0, 0, 1, 0,   5, 0, 0, 0, 1, 1, 0, 0);
        tbl[24] = mk(0, 0, 0, 0, 0, 0,   4, 0, 0, 1, 1, 0, 0, 0);
        tbl[25] = mk(0, 0, 0, 0, 0, 0,   3, 0, 0, 1, 1, 0, 0, 0);
        tbl[26] = mk(0, 0, 0, 0, 0, 0,   2, 0, 0, 1, 1, 0, 0, 0);
        tbl[27] = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0, 0);
        tbl[28] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0);
        tbl[29] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            run_vec(tbl[i], $sformatf("row%0d", i));
        end

        // cancel, selection and a coin during VEND: only the coin reacts (rejected)
        run_vec(mk(0, 2, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0), "vc_coin2");
        run_vec(mk(0, 1, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 0), "vc_coin1");
        run_vec(mk(0, 0, 1, 3, 0, 0,   3, 1, 3, 0, 1, 0, 0, 0), "vc_sel3");
        run_vec(mk(0, 1, 1, 2, 1, 0,   3, 1, 3, 0, 1, 1, 0, 0), "vc_cancel");
        run_vec(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0), "vc_ack");
        run_vec(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0), "vc_idle");
`ifdef SALES_AUDIT_EN
        check("audit sales_count", 32'(sales_count), 32'd3);
        check("audit refund_count", 32'(refund_count), 32'd1);
`endif

        // five vends from slot 2 exhaust its stock; sold_out rises with the last one
        for (int k = 0; k < 5; k++) begin
            run_vec(mk(0, 2, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0), $sformatf("drain%0d_coin2", k));
            run_vec(mk(0, 1, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 0), $sformatf("drain%0d_coin1", k));
            run_vec(mk(0, 0, 1, 2, 0, 0,   3, 1, 2, 0, 1, 0, 0, 0), $sformatf("drain%0d_sel", k));
            run_vec(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, (k == 4) ? 4'b0100 : 4'b0000),
                    $sformatf("drain%0d_ack", k));
        end
        run_vec(mk(0, 2, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 4'b0100), "empty_coin2");
        run_vec(mk(0, 1, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 4'b0100), "empty_coin1");
        run_vec(mk(0, 0, 1, 2, 0, 0,   3, 0, 0, 0, 0, 0, 1, 4'b0100), "empty_sel");

        // reset during CHANGE aborts the refund and restores every stock counter
        run_vec(mk(0, 0, 0, 0, 1, 0,   3, 0, 0, 0, 1, 0, 0, 4'b0100), "rst_cancel");
        run_vec(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0), "rst_in_change");
`ifdef SALES_AUDIT_EN
        check("rst sales_count", 32'(sales_count), 32'd0);
        check("rst refund_count", 32'(refund_count), 32'd0);
`endif
        run_vec(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0), "post_rst_idle");
        run_vec(mk(0, 2, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0), "post_rst_coin2");
        run_vec(mk(0, 1, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 0), "post_rst_coin1");
        run_vec(mk(0, 0, 1, 2, 0, 0,   3, 1, 2, 0, 1, 0, 0, 0), "post_rst_sel2");
        run_vec(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0), "post_rst_ack");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
